// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants.
// Used by the write-back stage and its round-robin arbiter.
package cpu_pkg;
    localparam int unsigned XLEN             = 32;
    localparam int unsigned REG_AW           = 5;
    localparam int unsigned FLUSH_CYCLES_DEF = 2;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wb_state_t;
endpackage

// File: rtl/wb_arbiter.sv
// 2:1 round-robin arbiter between the ALU and LSU result sources.
// The last-grant bit resets to ALU, so the LSU wins the first tie.
module wb_arbiter
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_alu,
    input  logic i_req_lsu,
    output logic o_gnt_alu,
    output logic o_gnt_lsu
);
    logic r_last_lsu;

    assign o_gnt_lsu = i_en & i_req_lsu & (~i_req_alu | ~r_last_lsu);
    assign o_gnt_alu = i_en & i_req_alu & (~i_req_lsu | r_last_lsu);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_lsu <= 1'b0;
        end else if (o_gnt_alu | o_gnt_lsu) begin
            r_last_lsu <= o_gnt_lsu;
        end
    end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: merges ALU and LSU results, writes the RF, redirects.
// Define WB_RETIRE_CNT_EN to build the 64-bit minstret counter.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int unsigned xlen         = XLEN,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic              alu_result_valid,
    input  logic [xlen-1:0]   alu_result,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [xlen-1:0]   alu_target,
    input  logic              alu_target_valid,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [xlen-1:0]   lsu_data,
    input  logic [REG_AW-1:0] lsu_rd,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [xlen-1:0]   rf_wdata,
    output logic              release_valid,
    output logic [REG_AW-1:0] release_rd,
    output logic              redirect_valid,
    output logic [xlen-1:0]   redirect_pc,
    output logic              flush,
    output logic              illegal,
    output logic [63:0]       minstret
);
    localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

    wb_state_t         r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_waddr;
    logic [xlen-1:0]   r_wdata;
    logic              r_rel_v;
    logic [REG_AW-1:0] r_rel_rd;
    logic              r_redir_v;
    logic [xlen-1:0]   r_pc;
    logic              r_flush;
    logic              r_illegal;

    logic              w_gnt_alu;
    logic              w_gnt_lsu;
    logic              w_legal;
    logic              w_redir;
    logic              w_ill;
    logic [REG_AW-1:0] w_rd;
    logic [xlen-1:0]   w_data;

    wb_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_en      (r_state == RUN),
        .i_req_alu (alu_valid),
        .i_req_lsu (lsu_valid),
        .o_gnt_alu (w_gnt_alu),
        .o_gnt_lsu (w_gnt_lsu)
    );

    assign w_legal = w_gnt_lsu | (w_gnt_alu & alu_result_valid);
    assign w_redir = w_gnt_alu & alu_target_valid;
    assign w_ill   = w_gnt_alu & ~alu_result_valid & ~alu_target_valid;
    assign w_rd    = w_gnt_lsu ? lsu_rd : alu_rd;
    assign w_data  = w_gnt_lsu ? lsu_data : alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_rf_we   <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_rel_v   <= 1'b0;
            r_rel_rd  <= '0;
            r_redir_v <= 1'b0;
            r_pc      <= '0;
            r_flush   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_rf_we   <= 1'b0;
            r_rel_v   <= 1'b0;
            r_redir_v <= 1'b0;
            r_illegal <= 1'b0;
            unique case (r_state)
                RUN: begin
                    if (w_legal) begin
                        r_rel_v  <= 1'b1;
                        r_rel_rd <= w_rd;
                        if (w_rd != '0) begin
                            r_rf_we <= 1'b1;
                            r_waddr <= w_rd;
                            r_wdata <= w_data;
                        end
                    end
                    if (w_redir) begin
                        r_redir_v <= 1'b1;
                        r_pc      <= alu_target;
                    end
                    if (w_redir | w_ill) begin
                        r_illegal <= w_ill;
                        r_flush   <= 1'b1;
                        r_cnt     <= CW'(1);
                        r_state   <= FLUSH;
                    end
                end
                FLUSH: begin
                    // The first flush cycle was counted when entering FLUSH.
                    if (r_cnt == CW'(FLUSH_CYCLES)) begin
                        r_state <= RUN;
                        r_flush <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_minstret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_minstret <= '0;
        end else if (w_legal) begin
            r_minstret <= r_minstret + 64'd1;
        end
    end

    assign minstret = r_minstret;
`else
    assign minstret = '0;
`endif

    assign alu_ready      = w_gnt_alu;
    assign lsu_ready      = w_gnt_lsu;
    assign rf_we          = r_rf_we;
    assign rf_waddr       = r_waddr;
    assign rf_wdata       = r_wdata;
    assign release_valid  = r_rel_v;
    assign release_rd     = r_rel_rd;
    assign redirect_valid = r_redir_v;
    assign redirect_pc    = r_pc;
    assign flush          = r_flush;
    assign illegal        = r_illegal;
endmodule
